// File: rtl/ob_mk_table_acc_pkg.sv
// Shared types for the order-book table accumulator: table entry, quantity widths,
// mode enum, command/response records and the carry-save helper.
package ob_mk_table_acc_pkg;

   localparam int TBL_N = 16;
   localparam int QTY_W = 8;
   // Wide enough for TBL_N entries at the maximum quantity, so no saturation is needed.
   localparam int ACC_W = QTY_W + $clog2(TBL_N);

   typedef logic [QTY_W-1:0] quantity_t;
   typedef logic [ACC_W-1:0] accum_quantity_t;

   typedef struct packed {
      quantity_t quantity;
   } table_t;

   typedef enum logic {
      COUNT     = 1'b0,
      THRESHOLD = 1'b1
   } acc_mode_t;

   typedef struct packed {
      acc_mode_t       mode;
      accum_quantity_t goal;
   } cmd_t;

   typedef struct packed {
      accum_quantity_t quantity;
      logic            goal_met;
   } rsp_t;

   typedef struct packed {
      accum_quantity_t s;
      accum_quantity_t c;
   } csa_pair_t;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   function automatic csa_pair_t csa_3_2(input accum_quantity_t a, input accum_quantity_t b,
                                         input accum_quantity_t d);
      csa_pair_t r;
      r.s = a ^ b ^ d;
      r.c = ((a & b) | (a & d) | (b & d)) << 1;
      return r;
   endfunction

endpackage

// File: rtl/ob_mk_table_acc_if.sv
// Command/response handshake bundle between the market kernel and the table accumulator.
interface ob_mk_table_acc_if #(parameter int RND_W = 2);
   import ob_mk_table_acc_pkg::*;

   logic             cmd_vld;
   logic             cmd_rdy;
   acc_mode_t        cmd_mode;
   accum_quantity_t  cmd_goal;
   logic             rsp_vld;
   logic             rsp_rdy;
   accum_quantity_t  rsp_quantity;
   logic             rsp_goal_met;
   logic [RND_W-1:0] rsp_rounds;

   modport master (
      output cmd_vld, cmd_mode, cmd_goal, rsp_rdy,
      input  cmd_rdy, rsp_vld, rsp_quantity, rsp_goal_met, rsp_rounds
   );

   modport slave (
      input  cmd_vld, cmd_mode, cmd_goal, rsp_rdy,
      output cmd_rdy, rsp_vld, rsp_quantity, rsp_goal_met, rsp_rounds
   );

endinterface

// File: rtl/ob_mk_table_acc_fsm.sv
// Control for the table accumulator: state, round counter, termination decode and handshake.
module ob_mk_table_acc_fsm #(
   parameter int EARLY_TERM_EN = 1,
   parameter int RND_W         = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cmd_vld_i,
   input  logic             rsp_rdy_i,
   input  logic             goal_hit_i,
   input  logic             last_round_i,
   input  logic             round_inv_i,
   output logic             cmd_rdy_o,
   output logic             rsp_vld_o,
   output logic             accept_o,
   output logic             latch_o,
   output logic             acc_en_o,
   output logic             drain_o,
   output logic [RND_W-1:0] rounds_o
);

   // Top bit of the encoding is the busy indicator, so cmd_rdy comes straight off a flop.
   typedef enum logic [2:0] {
      S_IDLE  = 3'b000,
      S_ACCUM = 3'b100,
      S_DRAIN = 3'b101,
      S_RESP  = 3'b110
   } state_e;

   state_e           state_q;
   logic             rsp_vld_q;
   logic [RND_W-1:0] rounds_q;
   logic             term_s;

   assign term_s = last_round_i || ((EARLY_TERM_EN != 0) && round_inv_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         rsp_vld_q <= 1'b0;
         rounds_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cmd_vld_i) begin
                  state_q  <= S_ACCUM;
                  rounds_q <= '0;
               end
            end
            S_ACCUM: begin
               if (goal_hit_i) begin
                  state_q <= S_DRAIN;
               end else begin
                  rounds_q <= rounds_q + RND_W'(1);
                  if (term_s) begin
                     state_q <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               state_q   <= S_RESP;
               rsp_vld_q <= 1'b1;
            end
            S_RESP: begin
               if (rsp_rdy_i) begin
                  state_q   <= S_IDLE;
                  rsp_vld_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= S_IDLE;
               rsp_vld_q <= 1'b0;
            end
         endcase
      end
   end

   // A goal hit suppresses both the latch and the accumulation; DRAIN folds in the held round.
   assign cmd_rdy_o = ~state_q[2];
   assign rsp_vld_o = rsp_vld_q;
   assign rounds_o  = rounds_q;
   assign accept_o  = (state_q == S_IDLE) && cmd_vld_i;
   assign latch_o   = (state_q == S_ACCUM) && !goal_hit_i;
   assign drain_o   = (state_q == S_DRAIN);
   assign acc_en_o  = latch_o || drain_o;

endmodule

// File: rtl/ob_mk_table_acc.sv
// Top-of-book quantity accumulator: per-round mux of MUX_N entries into a carry-save
// chain with acc_s/acc_c feedback, and a final carry-propagate add into the response.
module ob_mk_table_acc
   import ob_mk_table_acc_pkg::*;
#(
   parameter int N             = TBL_N,
   parameter int CSA_DEGREE_N  = 8,
   parameter int EARLY_TERM_EN = 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   ob_mk_table_acc_if.slave   bus,
   input  table_t [N-1:0]     tbl_i,
   input  logic   [N-1:0]     tbl_vld_i
);

   localparam int MUX_N    = CSA_DEGREE_N - 2;
   localparam int ROUNDS_N = ceil_div(N, MUX_N);
   localparam int RND_W    = $clog2(ROUNDS_N + 1);
   localparam int IDX_W    = (N > 1) ? $clog2(N) : 1;

   logic [ROUNDS_N-1:0] sel_q;
   accum_quantity_t     csa_in_q [MUX_N];
   accum_quantity_t     acc_s_q;
   accum_quantity_t     acc_c_q;
   accum_quantity_t     goal_q;
   acc_mode_t           mode_q;
   accum_quantity_t     rsp_qty_q;
   logic                rsp_met_q;

   accum_quantity_t     lane_s [MUX_N];
   logic                round_inv_s;
   accum_quantity_t     csa_s_s;
   accum_quantity_t     csa_c_s;
   accum_quantity_t     fin_sum_s;
   logic                goal_hit_s;
   logic                accept_s, latch_s, acc_en_s, drain_s;

   // Per-lane round select; out-of-range indices and invalid entries contribute zero.
   always_comb begin
      int idx;
      idx         = 0;
      round_inv_s = 1'b0;
      for (int l = 0; l < MUX_N; l++) begin
         lane_s[l] = '0;
      end
      for (int r = 0; r < ROUNDS_N; r++) begin
         for (int l = 0; l < MUX_N; l++) begin
            idx = N - 1 - r * MUX_N - l;
            if (sel_q[r] && (idx >= 0)) begin
               if (tbl_vld_i[idx[IDX_W-1:0]]) begin
                  lane_s[l] = accum_quantity_t'(tbl_i[idx[IDX_W-1:0]].quantity);
               end else begin
                  round_inv_s = 1'b1;
               end
            end else begin
               round_inv_s = round_inv_s;
            end
         end
      end
   end

   always_comb begin
      csa_pair_t p;
      p.s = acc_s_q;
      p.c = acc_c_q;
      for (int l = 0; l < MUX_N; l++) begin
         p = csa_3_2(p.s, p.c, csa_in_q[l]);
      end
      csa_s_s = p.s;
      csa_c_s = p.c;
   end

   assign fin_sum_s  = csa_s_s + csa_c_s;
   assign goal_hit_s = (mode_q == THRESHOLD) && ((acc_s_q + acc_c_q) >= goal_q);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sel_q     <= '0;
         acc_s_q   <= '0;
         acc_c_q   <= '0;
         goal_q    <= '0;
         mode_q    <= COUNT;
         rsp_qty_q <= '0;
         rsp_met_q <= 1'b0;
         for (int l = 0; l < MUX_N; l++) begin
            csa_in_q[l] <= '0;
         end
      end else if (accept_s) begin
         mode_q  <= bus.cmd_mode;
         goal_q  <= bus.cmd_goal;
         acc_s_q <= '0;
         acc_c_q <= '0;
         sel_q   <= ROUNDS_N'(1);
         for (int l = 0; l < MUX_N; l++) begin
            csa_in_q[l] <= '0;
         end
      end else begin
         if (latch_s) begin
            sel_q <= sel_q << 1;
            for (int l = 0; l < MUX_N; l++) begin
               csa_in_q[l] <= lane_s[l];
            end
         end
         if (acc_en_s) begin
            acc_s_q <= csa_s_s;
            acc_c_q <= csa_c_s;
         end
         // The drained CSA output is the final total, resolved on the way into RESP.
         if (drain_s) begin
            rsp_qty_q <= fin_sum_s;
            rsp_met_q <= (mode_q == THRESHOLD) && (fin_sum_s >= goal_q);
         end
      end
   end

   ob_mk_table_acc_fsm #(
      .EARLY_TERM_EN (EARLY_TERM_EN),
      .RND_W         (RND_W)
   ) u_fsm (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .cmd_vld_i    (bus.cmd_vld),
      .rsp_rdy_i    (bus.rsp_rdy),
      .goal_hit_i   (goal_hit_s),
      .last_round_i (sel_q[ROUNDS_N-1]),
      .round_inv_i  (round_inv_s),
      .cmd_rdy_o    (bus.cmd_rdy),
      .rsp_vld_o    (bus.rsp_vld),
      .accept_o     (accept_s),
      .latch_o      (latch_s),
      .acc_en_o     (acc_en_s),
      .drain_o      (drain_s),
      .rounds_o     (bus.rsp_rounds)
   );

   assign bus.rsp_quantity = rsp_qty_q;
   assign bus.rsp_goal_met = rsp_met_q;

endmodule

// File: tb/tb_ob_mk_table_acc.sv
// Directed and random transactions against an arithmetic round-sum model of the accumulator.
module tb_ob_mk_table_acc;
   import ob_mk_table_acc_pkg::*;

   localparam int N   = 16;
   localparam int MUX = 6;
   localparam int R   = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ob_mk_table_acc_if #(.RND_W(2)) bus ();
   table_t [N-1:0] tbl;
   logic   [N-1:0] tbl_vld;

   ob_mk_table_acc #(.N(N), .CSA_DEGREE_N(8), .EARLY_TERM_EN(1)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .bus       (bus),
      .tbl_i     (tbl),
      .tbl_vld_i (tbl_vld)
   );

   int total = 0;
   int bad   = 0;
   int q_tab [N];
   int nvld;
   int oq, orr, om;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic load_table();
      for (int i = 0; i < N; i++) begin
         tbl[i].quantity = q_tab[i][QTY_W-1:0];
         tbl_vld[i]      = (i >= N - nvld);
      end
   endtask

   // Round sums from the entry ranges; termination is the earliest of: last round,
   // first round holding an invalid entry, or two rounds after the goal is reached.
   task automatic model(input int mode, input int goal, output int eq, output int er,
                        output int em, output int el);
      int rs [R];
      bit rinv [R];
      int nat, gk, pre, idx;
      bit gstop;
      for (int k = 0; k < R; k++) begin
         rs[k] = 0; rinv[k] = 1'b0;
         for (int l = 0; l < MUX; l++) begin
            idx = N - 1 - k * MUX - l;
            if (idx >= 0) begin
               if (idx >= N - nvld) rs[k] += q_tab[idx];
               else rinv[k] = 1'b1;
            end
         end
      end
      nat = R;
      for (int k = R - 1; k >= 0; k--) if (rinv[k]) nat = k + 1;
      gk = 1000;
      if (mode == 1) begin
         if (goal == 0) gk = -2;
         else begin
            pre = 0;
            for (int k = 0; k < R; k++) begin
               pre += rs[k];
               if (pre >= goal && gk == 1000) gk = k;
            end
         end
      end
      gstop = (gk + 2 < nat);
      er = gstop ? gk + 2 : nat;
      eq = 0;
      for (int k = 0; k < er; k++) eq += rs[k];
      em = (mode == 1 && eq >= goal) ? 1 : 0;
      el = er + 2 + (gstop ? 1 : 0);
   endtask

   task automatic run(input string tag, input int mode, input int goal);
      int eq, er, em, el, cyc;
      model(mode, goal, eq, er, em, el);
      load_table();
      check({tag, ".cmd_rdy"}, bus.cmd_rdy, 1);
      bus.cmd_vld  = 1'b1;
      bus.cmd_mode = acc_mode_t'(mode[0]);
      bus.cmd_goal = accum_quantity_t'(goal);
      @(negedge clk);
      bus.cmd_vld = 1'b0;
      cyc = 1;
      while (!bus.rsp_vld && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, ".latency"}, cyc, el);
      check({tag, ".quantity"}, bus.rsp_quantity, eq);
      check({tag, ".rounds"}, bus.rsp_rounds, er);
      check({tag, ".goal_met"}, bus.rsp_goal_met, em);
      oq = bus.rsp_quantity; orr = bus.rsp_rounds; om = bus.rsp_goal_met;
      if (bus.rsp_rdy) begin
         @(negedge clk);
         check({tag, ".idle_rdy"}, bus.cmd_rdy, 1);
         check({tag, ".idle_vld"}, bus.rsp_vld, 0);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.cmd_vld = 1'b0; bus.cmd_mode = COUNT; bus.cmd_goal = '0; bus.rsp_rdy = 1'b1;
      nvld = 0;
      for (int i = 0; i < N; i++) q_tab[i] = 0;
      load_table();
      repeat (3) @(negedge clk);
      check("reset.cmd_rdy", bus.cmd_rdy, 1);
      check("reset.rsp_vld", bus.rsp_vld, 0);
      check("reset.quantity", bus.rsp_quantity, 0);
      check("reset.goal_met", bus.rsp_goal_met, 0);
      check("reset.rounds", bus.rsp_rounds, 0);
      rst = 1'b0;
      @(negedge clk);

      // 1: entry i holds i+1, full table, COUNT
      nvld = 16;
      for (int i = 0; i < N; i++) q_tab[i] = i + 1;
      run("full_count", 0, 0);
      check("full_count.q136", oq, 136);
      check("full_count.r3", orr, 3);

      // 2: early termination in round 1
      nvld = 7;
      for (int i = 0; i < N; i++) q_tab[i] = 10;
      run("early_term", 0, 0);
      check("early_term.q70", oq, 70);
      check("early_term.r2", orr, 2);

      // 3: goal reached after round 0
      nvld = 16;
      for (int i = 0; i < N; i++) q_tab[i] = 5;
      run("thr_hit", 1, 25);
      check("thr_hit.q60", oq, 60);
      check("thr_hit.met", om, 1);

      // 4: goal never reached
      for (int i = 0; i < N; i++) q_tab[i] = 1;
      run("thr_miss", 1, 100);
      check("thr_miss.q16", oq, 16);
      check("thr_miss.met", om, 0);

      // boundaries: empty table, zero goal
      nvld = 0;
      run("empty", 0, 0);
      check("empty.r1", orr, 1);
      nvld = 16;
      for (int i = 0; i < N; i++) q_tab[i] = 7;
      run("goal_zero", 1, 0);
      check("goal_zero.met", om, 1);

      // 5: response stall with a command pulsed while busy
      for (int i = 0; i < N; i++) q_tab[i] = i + 1;
      bus.rsp_rdy = 1'b0;
      run("stall", 0, 0);
      for (int i = 0; i < 4; i++) begin
         bus.cmd_vld = 1'b1;
         @(negedge clk);
         check("stall.vld", bus.rsp_vld, 1);
         check("stall.qty", bus.rsp_quantity, 136);
         check("stall.rounds", bus.rsp_rounds, 3);
         check("stall.cmd_rdy", bus.cmd_rdy, 0);
      end
      bus.cmd_vld = 1'b0;
      bus.rsp_rdy = 1'b1;
      @(negedge clk);
      check("stall.release_rdy", bus.cmd_rdy, 1);
      check("stall.release_vld", bus.rsp_vld, 0);
      @(negedge clk);
      check("stall.no_ghost", bus.rsp_vld, 0);

      // 6: reset during ACCUM round 1, then a clean retry
      load_table();
      bus.cmd_vld = 1'b1; bus.cmd_mode = COUNT; bus.cmd_goal = '0;
      @(negedge clk);
      bus.cmd_vld = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid.cmd_rdy", bus.cmd_rdy, 1);
      check("rst_mid.rsp_vld", bus.rsp_vld, 0);
      rst = 1'b0;
      run("rst_retry", 0, 0);
      check("rst_retry.q136", oq, 136);

      // random tables, modes and goals
      for (int t = 0; t < 24; t++) begin
         nvld = $urandom_range(0, 16);
         for (int i = 0; i < N; i++) q_tab[i] = $urandom_range(0, 255);
         run($sformatf("rand%0d", t), $urandom_range(0, 1),
             ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 2000));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
